// File: rtl/devolvedor_troco.sv
// Change dispenser: computes credit minus price and pays it out coin by coin
// (1,00 / 0,50 / 0,25) from three refillable stocks, one handshake per coin.
module devolvedor_troco #(
    parameter int unsigned ESTOQUE_INICIAL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [3:0] valorAcumulado,
    input  logic [3:0] preco,
    input  logic       recarga,
    input  logic       moedaAck,
    output logic [1:0] moedaSaida,
    output logic       moedaValida,
    output logic       ocupado,
    output logic       concluido,
    output logic       erro,
    output logic [3:0] trocoRestante
);

    localparam int unsigned W         = 4;
    localparam int unsigned VALOR_MAX = 8;

    localparam logic [2:0] OCIOSO    = 3'd0;
    localparam logic [2:0] CALCULA   = 3'd1;
    localparam logic [2:0] SELECIONA = 3'd2;
    localparam logic [2:0] ENTREGA   = 3'd3;
    localparam logic [2:0] FIM       = 3'd4;
    localparam logic [2:0] FALHA     = 3'd5;

    localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
    localparam logic [1:0] MOEDA_025     = 2'b01;
    localparam logic [1:0] MOEDA_050     = 2'b10;
    localparam logic [1:0] MOEDA_100     = 2'b11;

    localparam logic [W-1:0] ESTOQUE_RST = W'(ESTOQUE_INICIAL);

    logic [2:0]   estado, estado_d;
    logic [W-1:0] credito_q, credito_d;
    logic [W-1:0] preco_q, preco_d;
    logic [W-1:0] troco_d;
    logic [W-1:0] estoque_100, estoque_100_d;
    logic [W-1:0] estoque_050, estoque_050_d;
    logic [W-1:0] estoque_025, estoque_025_d;
    logic [1:0]   saida_d;
    logic         valida_d;
    logic         ocupado_d;
    logic         concluido_d;
    logic         erro_d;
    logic [1:0]   moeda_sel;

    // Coin value in 0,25 units.
    function automatic logic [W-1:0] valor_de(input logic [1:0] moeda);
        case (moeda)
            MOEDA_100: valor_de = W'(4);
            MOEDA_050: valor_de = W'(2);
            MOEDA_025: valor_de = W'(1);
            default:   valor_de = '0;
        endcase
    endfunction

    // Largest coin that fits the remaining change and is still in stock.
    always_comb begin
        moeda_sel = MOEDA_NENHUMA;
        if (trocoRestante >= W'(4) && estoque_100 != '0) begin
            moeda_sel = MOEDA_100;
        end else if (trocoRestante >= W'(2) && estoque_050 != '0) begin
            moeda_sel = MOEDA_050;
        end else if (trocoRestante >= W'(1) && estoque_025 != '0) begin
            moeda_sel = MOEDA_025;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        estado_d      = estado;
        credito_d     = credito_q;
        preco_d       = preco_q;
        troco_d       = trocoRestante;
        estoque_100_d = estoque_100;
        estoque_050_d = estoque_050;
        estoque_025_d = estoque_025;
        saida_d       = moedaSaida;
        valida_d      = 1'b0;
        ocupado_d     = 1'b0;
        concluido_d   = 1'b0;
        erro_d        = 1'b0;

        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    credito_d = valorAcumulado;
                    preco_d   = preco;
                    troco_d   = '0;
                    estado_d  = CALCULA;
                end else if (recarga) begin
                    estoque_100_d = ESTOQUE_RST;
                    estoque_050_d = ESTOQUE_RST;
                    estoque_025_d = ESTOQUE_RST;
                end
            end
            CALCULA: begin
                if (credito_q > W'(VALOR_MAX) || preco_q > W'(VALOR_MAX) ||
                    credito_q < preco_q) begin
                    estado_d = FALHA;
                end else begin
                    troco_d  = credito_q - preco_q;
                    estado_d = SELECIONA;
                end
            end
            SELECIONA: begin
                if (trocoRestante == '0) begin
                    estado_d = FIM;
                end else if (moeda_sel == MOEDA_NENHUMA) begin
                    estado_d = FALHA;
                end else begin
                    saida_d  = moeda_sel;
                    estado_d = ENTREGA;
                end
            end
            ENTREGA: begin
                if (moedaAck) begin
                    // Selection guarantees the coin fits; the guards only keep counters from wrapping.
                    if (trocoRestante >= valor_de(moedaSaida)) begin
                        troco_d = trocoRestante - valor_de(moedaSaida);
                    end else begin
                        troco_d = '0;
                    end
                    case (moedaSaida)
                        MOEDA_100: if (estoque_100 != '0) estoque_100_d = estoque_100 - W'(1);
                        MOEDA_050: if (estoque_050 != '0) estoque_050_d = estoque_050 - W'(1);
                        MOEDA_025: if (estoque_025 != '0) estoque_025_d = estoque_025 - W'(1);
                        default: ;
                    endcase
                    estado_d = SELECIONA;
                end
            end
            FIM:     estado_d = OCIOSO;
            FALHA:   estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        valida_d    = (estado_d == ENTREGA);
        ocupado_d   = (estado_d != OCIOSO);
        concluido_d = (estado_d == FIM);
        erro_d      = (estado_d == FALHA);
        if (!valida_d) begin
            saida_d = MOEDA_NENHUMA;
        end
    end

    // State and registered outputs; reset drops any coin still awaiting ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            credito_q     <= '0;
            preco_q       <= '0;
            trocoRestante <= '0;
            estoque_100   <= ESTOQUE_RST;
            estoque_050   <= ESTOQUE_RST;
            estoque_025   <= ESTOQUE_RST;
            moedaSaida    <= MOEDA_NENHUMA;
            moedaValida   <= 1'b0;
            ocupado       <= 1'b0;
            concluido     <= 1'b0;
            erro          <= 1'b0;
        end else begin
            estado        <= estado_d;
            credito_q     <= credito_d;
            preco_q       <= preco_d;
            trocoRestante <= troco_d;
            estoque_100   <= estoque_100_d;
            estoque_050   <= estoque_050_d;
            estoque_025   <= estoque_025_d;
            moedaSaida    <= saida_d;
            moedaValida   <= valida_d;
            ocupado       <= ocupado_d;
            concluido     <= concluido_d;
            erro          <= erro_d;
        end
    end

endmodule

// File: tb/tb_devolvedor_troco.sv
// Directed bench for devolvedor_troco: change payout, failures, stock
// exhaustion, ignored inputs and reset during a pending coin.
module tb_devolvedor_troco;

    logic       clk;
    logic       rst_n;
    logic       iniciar;
    logic [3:0] valorAcumulado;
    logic [3:0] preco;
    logic       recarga;
    logic       moedaAck;
    logic [1:0] moedaSaida;
    logic       moedaValida;
    logic       ocupado;
    logic       concluido;
    logic       erro;
    logic [3:0] trocoRestante;

    int n_testes = 0;
    int n_falhas = 0;

    devolvedor_troco #(.ESTOQUE_INICIAL(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iniciar       (iniciar),
        .valorAcumulado(valorAcumulado),
        .preco         (preco),
        .recarga       (recarga),
        .moedaAck      (moedaAck),
        .moedaSaida    (moedaSaida),
        .moedaValida   (moedaValida),
        .ocupado       (ocupado),
        .concluido     (concluido),
        .erro          (erro),
        .trocoRestante (trocoRestante)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic confere_estoques(input string tag, input logic [3:0] e100,
                                    input logic [3:0] e050, input logic [3:0] e025);
        verifica(tag, 32'({dut.estoque_100, dut.estoque_050, dut.estoque_025}),
                 32'({e100, e050, e025}));
    endtask

    task automatic reinicia();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic iniciar_op(input logic [3:0] credito, input logic [3:0] custo);
        valorAcumulado = credito;
        preco          = custo;
        iniciar        = 1'b1;
        tick();
        iniciar        = 1'b0;
    endtask

    task automatic espera_valida();
        int n = 0;
        while (!moedaValida && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Waits for a coin, checks it, holds one cycle, then acknowledges it.
    task automatic espera_moeda(input string tag, input logic [1:0] esp);
        espera_valida();
        verifica({tag, "_valida"}, 32'(moedaValida), 32'd1);
        verifica(tag, 32'(moedaSaida), 32'(esp));
        tick();
        verifica({tag, "_estavel"}, 32'({moedaValida, moedaSaida}), 32'({1'b1, esp}));
        moedaAck = 1'b1;
        tick();
        moedaAck = 1'b0;
    endtask

    task automatic espera_fim(input string tag, input logic ok, input logic [3:0] esp_troco);
        int n = 0;
        while (!concluido && !erro && n < 30) begin
            tick();
            n++;
        end
        verifica({tag, "_concluido"}, 32'(concluido), 32'(ok));
        verifica({tag, "_erro"}, 32'(erro), 32'(!ok));
        verifica({tag, "_troco"}, 32'(trocoRestante), 32'(esp_troco));
        tick();
        verifica({tag, "_pulso"}, 32'({concluido, erro, ocupado}), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        iniciar        = 1'b0;
        valorAcumulado = '0;
        preco          = '0;
        recarga        = 1'b0;
        moedaAck       = 1'b0;
        tick();
        tick();
        verifica("reset_saidas",
                 32'({moedaSaida, moedaValida, ocupado, concluido, erro, trocoRestante}), 32'd0);
        confere_estoques("reset_estoques", 4'd4, 4'd4, 4'd4);
        rst_n = 1'b1;

        // 8 - 3 = 5 -> 1,00 + 0,25
        iniciar_op(4'd8, 4'd3);
        verifica("t1_ocupado", 32'(ocupado), 32'd1);
        espera_moeda("t1_m1", 2'b11);
        espera_moeda("t1_m2", 2'b01);
        espera_fim("t1", 1'b1, 4'd0);
        confere_estoques("t1_estoques", 4'd3, 4'd4, 4'd3);

        // 2 - 5: insufficient credit, erro two cycles after iniciar
        iniciar_op(4'd2, 4'd5);
        verifica("t2_calcula", 32'({erro, moedaValida, ocupado}), 32'b001);
        tick();
        verifica("t2_erro", 32'({erro, moedaValida, ocupado}), 32'b101);
        tick();
        verifica("t2_ocioso", 32'({erro, moedaValida, ocupado}), 32'b000);
        confere_estoques("t2_estoques", 4'd3, 4'd4, 4'd3);

        // 1,00 stock exhaustion with fallback to 0,50
        reinicia();
        for (int i = 0; i < 4; i++) begin
            iniciar_op(4'd8, 4'd4);
            espera_moeda("t3_m100", 2'b11);
            espera_fim("t3_op", 1'b1, 4'd0);
        end
        confere_estoques("t3_sem100", 4'd0, 4'd4, 4'd4);
        iniciar_op(4'd8, 4'd4);
        espera_moeda("t3_m050a", 2'b10);
        espera_moeda("t3_m050b", 2'b10);
        espera_fim("t3_fallback", 1'b1, 4'd0);
        confere_estoques("t3_estoques", 4'd0, 4'd2, 4'd4);

        // Drain 0,25 stock, then 5 - 4 has no eligible coin
        for (int i = 0; i < 4; i++) begin
            iniciar_op(4'd1, 4'd0);
            espera_moeda("t4_m025", 2'b01);
            espera_fim("t4_dreno", 1'b1, 4'd0);
        end
        confere_estoques("t4_drenado", 4'd0, 4'd2, 4'd0);
        iniciar_op(4'd5, 4'd4);
        espera_fim("t4_sem_moeda", 1'b0, 4'd1);
        verifica("t4_troco_mantido", 32'(trocoRestante), 32'd1);
        verifica("t4_sem_valida", 32'(moedaValida), 32'd0);
        iniciar_op(4'd9, 4'd0);
        espera_fim("t4_credito9", 1'b0, 4'd0);

        // iniciar / recarga while busy are ignored
        iniciar_op(4'd4, 4'd0);
        espera_valida();
        verifica("t5_m1", 32'(moedaSaida), 32'(2'b10));
        valorAcumulado = 4'd8;
        preco          = 4'd0;
        iniciar        = 1'b1;
        recarga        = 1'b1;
        tick();
        iniciar = 1'b0;
        recarga = 1'b0;
        verifica("t5_ignora_saida", 32'({moedaValida, moedaSaida}), 32'b110);
        verifica("t5_ignora_troco", 32'(trocoRestante), 32'd4);
        confere_estoques("t5_ignora_estoques", 4'd0, 4'd2, 4'd0);
        moedaAck = 1'b1;
        tick();
        moedaAck = 1'b0;
        espera_moeda("t5_m2", 2'b10);
        espera_fim("t5", 1'b1, 4'd0);
        confere_estoques("t5_vazio", 4'd0, 4'd0, 4'd0);

        // iniciar wins over recarga; zero change completes directly
        valorAcumulado = 4'd1;
        preco          = 4'd1;
        iniciar        = 1'b1;
        recarga        = 1'b1;
        tick();
        iniciar = 1'b0;
        recarga = 1'b0;
        espera_fim("t5_zero", 1'b1, 4'd0);
        confere_estoques("t5_iniciar_vence", 4'd0, 4'd0, 4'd0);
        recarga = 1'b1;
        tick();
        recarga = 1'b0;
        confere_estoques("t5_recarga", 4'd4, 4'd4, 4'd4);
        moedaAck = 1'b1;
        tick();
        moedaAck = 1'b0;
        verifica("t5_ack_ocioso", 32'({ocupado, moedaValida, trocoRestante}), 32'd0);
        confere_estoques("t5_ack_estoques", 4'd4, 4'd4, 4'd4);

        // Ack stall, then reset while a coin is pending
        iniciar_op(4'd8, 4'd0);
        espera_valida();
        verifica("t6_m1", 32'({moedaValida, moedaSaida}), 32'b111);
        begin
            logic estavel = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (moedaSaida !== 2'b11 || moedaValida !== 1'b1) estavel = 1'b0;
            end
            verifica("t6_estavel", 32'(estavel), 32'd1);
        end
        verifica("t6_troco_parado", 32'(trocoRestante), 32'd8);
        rst_n = 1'b0;
        tick();
        verifica("t6_reset_saidas",
                 32'({moedaSaida, moedaValida, ocupado, concluido, erro, trocoRestante}), 32'd0);
        confere_estoques("t6_reset_estoques", 4'd4, 4'd4, 4'd4);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
